// File: rtl/voice_allocator_pkg.sv
// Shared event codes, waveform codes, limits and FSM encoding for the
// polyphonic voice allocator.
package voice_allocator_pkg;

    localparam logic [1:0] EV_NOTE_OFF = 2'd0;
    localparam logic [1:0] EV_NOTE_ON  = 2'd1;
    localparam logic [1:0] EV_FORM     = 2'd2;
    localparam logic [1:0] EV_PW       = 2'd3;

    localparam logic [2:0] FORM_SAW      = 3'd0;
    localparam logic [2:0] FORM_REVSAW   = 3'd1;
    localparam logic [2:0] FORM_TRIANGLE = 3'd2;
    localparam logic [2:0] FORM_SQUARE   = 3'd3;
    localparam logic [2:0] FORM_PULSE25  = 3'd4;
    localparam logic [2:0] FORM_MAX      = 3'd4;

    localparam logic [6:0] PW_MAX = 7'd100;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_COMMIT
    } state_t;

endpackage

// File: rtl/voice_age_rank.sv
// Per-voice age ranking; rank NVOICES-1 marks the least recently triggered
// voice. Touching a voice makes it youngest and ages everything younger.
module voice_age_rank #(
    parameter int NVOICES = 4
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       touch,
    input  logic [$clog2(NVOICES)-1:0] touch_idx,
    output logic [$clog2(NVOICES)-1:0] oldest_idx
);

    localparam int IW = $clog2(NVOICES);

    logic [IW-1:0] r_rank [NVOICES];
    logic [IW-1:0] w_oldest;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            for (int unsigned i = 0; i < NVOICES; i++) begin
                r_rank[i] <= IW'(i);
            end
        end else if (touch) begin
            for (int unsigned i = 0; i < NVOICES; i++) begin
                if (IW'(i) == touch_idx) begin
                    r_rank[i] <= '0;
                end else if (r_rank[i] < r_rank[touch_idx]) begin
                    r_rank[i] <= r_rank[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_oldest = '0;
        for (int unsigned i = 0; i < NVOICES; i++) begin
            if (r_rank[i] == IW'(NVOICES - 1)) begin
                w_oldest = IW'(i);
            end
        end
    end

    assign oldest_idx = w_oldest;

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: accepts note/config events, scans the voice
// slots one per cycle, then commits a single voice update.
module voice_allocator
    import voice_allocator_pkg::*;
#(
    parameter int NVOICES  = 4,
    parameter int PW_RESET = 50
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   ev_valid,
    output logic                   ev_ready,
    input  logic [1:0]             ev_type,
    input  logic [7:0]             ev_data,
    output logic [8*NVOICES-1:0]   voice_note,
    output logic [NVOICES-1:0]     voice_gate,
    output logic [NVOICES-1:0]     voice_retrig,
    output logic                   steal,
    output logic [2:0]             form,
    output logic [6:0]             pulse_width
);

    localparam int IW = $clog2(NVOICES);

    state_t        r_state;
    state_t        w_next;
    logic          r_ready;
    logic          r_is_on;
    logic [6:0]    r_note;
    logic [IW-1:0] r_idx;
    logic          r_match;
    logic [IW-1:0] r_match_idx;
    logic          r_free;
    logic [IW-1:0] r_free_idx;

    logic          w_accept;
    logic          w_note_ev;
    logic          w_apply;
    logic          w_touch;
    logic          w_steal;
    logic [IW-1:0] w_target;
    logic [IW-1:0] w_oldest;

    assign ev_ready = r_ready;

    voice_age_rank #(
        .NVOICES(NVOICES)
    ) u_rank (
        .CLK        (CLK),
        .RESET      (RESET),
        .touch      (w_touch),
        .touch_idx  (w_target),
        .oldest_idx (w_oldest)
    );

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_accept  = ev_valid & r_ready;
        w_note_ev = !ev_type[1] && !ev_data[7];
        w_target  = w_oldest;
        w_steal   = 1'b0;
        if (r_match) begin
            w_target = r_match_idx;
        end else if (r_free) begin
            w_target = r_free_idx;
        end else begin
            w_steal = 1'b1;
        end
        w_apply = (r_state == ST_COMMIT) && (r_is_on || r_match);
        w_touch = (r_state == ST_COMMIT) && r_is_on;
        case (r_state)
            ST_IDLE:   if (w_accept && w_note_ev) w_next = ST_SCAN;
            ST_SCAN:   if (r_idx == IW'(NVOICES - 1)) w_next = ST_COMMIT;
            ST_COMMIT: w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_ready      <= 1'b0;
            r_is_on      <= 1'b0;
            r_note       <= '0;
            r_idx        <= '0;
            r_match      <= 1'b0;
            r_match_idx  <= '0;
            r_free       <= 1'b0;
            r_free_idx   <= '0;
            voice_note   <= '0;
            voice_gate   <= '0;
            voice_retrig <= '0;
            steal        <= 1'b0;
            form         <= FORM_SAW;
            pulse_width  <= 7'(PW_RESET);
        end else begin
            r_ready      <= (w_next == ST_IDLE);
            voice_retrig <= '0;
            steal        <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        case (ev_type)
                            EV_FORM: if (ev_data[2:0] <= FORM_MAX) form <= ev_data[2:0];
                            EV_PW:   pulse_width <= (ev_data[6:0] > PW_MAX) ? PW_MAX : ev_data[6:0];
                            default: begin
                                r_is_on <= (ev_type == EV_NOTE_ON);
                                r_note  <= ev_data[6:0];
                            end
                        endcase
                        r_idx   <= '0;
                        r_match <= 1'b0;
                        r_free  <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    if (voice_gate[r_idx] && voice_note[8*r_idx +: 8] == {1'b0, r_note}) begin
                        r_match     <= 1'b1;
                        r_match_idx <= r_idx;
                    end
                    if (!voice_gate[r_idx] && !r_free) begin
                        r_free     <= 1'b1;
                        r_free_idx <= r_idx;
                    end
                    r_idx <= r_idx + 1'b1;
                end
                ST_COMMIT: begin
                    // Note-off only releases the gate; the note stays for the release tail.
                    if (w_apply) begin
                        voice_gate[w_target] <= r_is_on;
                        if (r_is_on) begin
                            voice_note[8*w_target +: 8] <= {1'b0, r_note};
                            voice_retrig[w_target]      <= 1'b1;
                            steal                       <= w_steal;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
Polyphonic voice scheduler in front of the synth datapath. Accepts note-on, note-off and waveform-config events over a valid/ready handshake, and assigns notes to NVOICES voice slots. Each slot drives one note2dds_1st_gen → DDS → form_wave chain. Also holds the global form and pulse_width settings that all form_wave instances share.

Parameters:
NVOICES, 4, number of voice slots (2..8)
PW_RESET, 50, pulse_width value after reset

Ports:
CLK  in  1  system clock, all logic on rising edge
RESET  in  1  synchronous, active-low reset (RESET==0 resets on the next CLK edge)
ev_valid  in  1  event present
ev_ready  out  1  block can accept an event this cycle
ev_type  in  2  0=note-off, 1=note-on, 2=set form, 3=set pulse width
ev_data  in  8  note number, form code, or pulse width
voice_note  out  8*NVOICES  per-voice NOTE; slot i occupies bits [8i+7:8i]
voice_gate  out  NVOICES  voice i sounding
voice_retrig  out  NVOICES  1-cycle pulse; resets DDS phase of voice i
steal  out  1  1-cycle pulse when a sounding voice was stolen
form  out  3  form_wave selector (0 saw, 1 revsaw, 2 triangle, 3 square, 4 pulse25)
pulse_width  out  7  pulse width, 0..100

Behaviour:
- Reset values:
  - voice_note=0, voice_gate=0, voice_retrig=0, steal=0.
  - form=0, pulse_width=PW_RESET, ev_ready=0.
  - Age ranks: voice i gets rank i, where rank NVOICES-1 is oldest.
  - FSM=IDLE. ev_ready rises on the first edge with RESET=1.
- FSM states: IDLE, SCAN, COMMIT.
  - ev_ready=1 only in IDLE.
  - An event is accepted on an edge where ev_valid&ev_ready.
- Config events (type 2/3) are accepted in IDLE and applied at the accept edge. The FSM stays IDLE, so there is no back-pressure.
  - form: ev_data[2:0] is applied if ≤4. Codes 5..7 are ignored and form is held. ev_data[7:3] is ignored.
  - pulse width: ev_data[6:0] is applied, saturated to 100.
- Note events: ev_data[6:0] is the note; ev_data[7]=1 means the event is accepted and dropped (no state change).
  - Accept edge: latch type and note, go to SCAN.
  - SCAN: one voice examined per cycle, index 0..NVOICES-1, for NVOICES cycles. Records:
    - match: gate=1 and note equal
    - lowest-index free voice (gate=0)
    - voice with the oldest rank
  - COMMIT: one cycle. All output updates land on the COMMIT edge, i.e. NVOICES+1 edges after the accept edge. Then return to IDLE; ev_ready is high in the following cycle.
- Note-on target priority:
  1. Matching voice (retrigger; no duplicate notes).
  2. Lowest-index free voice.
  3. Oldest voice (steal=1).
- Note-on result: target gets note and gate=1; voice_retrig[target] is high for exactly the one cycle following the COMMIT edge.
- Rank update on note-on: target rank becomes 0; every voice with rank < the target's old rank increments. Ranks remain a permutation of 0..NVOICES-1.
- Note-off: the matching voice gets gate=0. Its note is held, for release tails. Ranks are unchanged. No match means no change, no pulse.
- At most one voice changes per event. steal and retrig are never high outside the post-COMMIT cycle.
- ev_valid while busy (SCAN/COMMIT) has no effect. The event must be held by the sender until ev_ready.
- RESET=0 in any state, including mid-SCAN or at COMMIT: next edge forces all reset values and discards the in-flight event. No partial commit.

Decomposition:
- Shared package holds:
  - event type codes EV_NOTE_OFF/EV_NOTE_ON/EV_FORM/EV_PW
  - form codes FORM_SAW..FORM_PULSE25 and FORM_MAX=4
  - PW_MAX=100
  - FSM state encoding
- One sub-module: voice_age_rank. It keeps NVOICES rank registers of $clog2(NVOICES) bits each, and has:
  - a "touch(index)" strobe that applies the rank-update rule
  - an "oldest index" output
  - reset behaviour per the rank reset values above.

Test Plan:
1. Release reset, note-on 69 → 5 edges after accept (NVOICES=4): voice_note[7:0]=69, voice_gate=4'b0001, voice_retrig=4'b0001 for 1 cycle, steal=0; ev_ready low for the 5 busy cycles.
2. Note-on 60,62,64,65 → voices 0..3, gate=4'b1111; then note-on 67 → voice 0 gets 67, steal=1 pulse, retrig=4'b0001; voices 1..3 unchanged.
3. From state 2: note-off 62 → gate=4'b1101, voice 1 note stays 62; note-on 70 → voice 1, steal=0; note-off 99 (absent) → no output change.
4. Note-on 64 while held on voice 2 → retrig=4'b0100, no other voice changes; then two new note-ons with all voices busy → oldest voices steal in order 3, then 0, not voice 2.
5. Config: form 3 → form=3 at the accept edge; form 6 → form stays 3; pw 120 → pulse_width=100; pw 25 → 25; ev_ready stays 1 throughout.
6. RESET=0 during second SCAN cycle of a note-on → next edge: all gates 0, notes 0, form 0, pulse_width 50; no retrig pulse; ev_ready=1 one edge after RESET returns to 1.
